// File: rtl/hit_merge_fifo.sv
// Merges up/down half hit streams into one timestamped FIFO; out_valid_o/out_data_o come from registered state only.
// Latency: a hit captured at edge N is visible at the output from edge N onward.
// Backpressure: out_ready_i pops the head word; hits arriving with no free slot are dropped and counted.
module hit_merge_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 15,
    parameter int TS_W   = 8
) (
    input  logic                        sys_clock,
    input  logic                        sys_reset,
    input  logic                        up_valid_i,
    input  logic [ADDR_W-1:0]           up_addr_i,
    input  logic                        down_valid_i,
    input  logic [ADDR_W-1:0]           down_addr_i,
    input  logic                        ts_clear_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic [TS_W+ADDR_W:0]        out_data_o,
    output logic [$clog2(DEPTH):0]      fifo_level_o,
    output logic                        overflow_o,
    output logic [7:0]                  drop_cnt_o,
    input  logic                        drop_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef struct packed {
        logic              src;
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
    } hit_t;

    hit_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] down_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] free;
    logic [TS_W-1:0]  ts;
    logic [7:0]       drop_cnt;
    logic             overflow;

    logic             up_wr;
    logic             down_wr;
    logic             pop;
    logic [1:0]       n_wr;
    logic [1:0]       n_drop;
    logic [8:0]       drop_sum;
    hit_t             up_hit;
    hit_t             down_hit;

    // Free space comes from the registered level, so a same-cycle pop never makes room.
    assign free     = DEPTH_L - level;
    assign up_wr    = up_valid_i && (free != '0);
    assign down_wr  = down_valid_i && (up_valid_i ? (free >= LVL_W'(2)) : (free != '0));
    assign n_wr     = {1'b0, up_wr} + {1'b0, down_wr};
    assign n_drop   = ({1'b0, up_valid_i} + {1'b0, down_valid_i}) - n_wr;
    assign pop      = (level != '0) && out_ready_i;
    assign down_ptr = up_wr ? wptr + PTR_W'(1) : wptr;
    assign drop_sum = {1'b0, drop_cnt} + 9'(n_drop);

    assign up_hit   = '{src: 1'b0, ts: ts, addr: up_addr_i};
    assign down_hit = '{src: 1'b1, ts: ts, addr: down_addr_i};

    always_ff @(posedge sys_clock) begin
        if (!sys_reset) begin
            if (up_wr) begin
                mem[wptr] <= up_hit;
            end
            if (down_wr) begin
                mem[down_ptr] <= down_hit;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            ts       <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            wptr  <= wptr + PTR_W'(n_wr);
            rptr  <= rptr + PTR_W'(pop);
            level <= level + LVL_W'(n_wr) - LVL_W'(pop);
            ts    <= ts_clear_i ? '0 : ts + TS_W'(1);
            // A clear coinciding with drops restarts the count from this cycle's drops.
            if (drop_clr_i) begin
                drop_cnt <= 8'(n_drop);
                overflow <= (n_drop != 2'd0);
            end else begin
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
                if (n_drop != 2'd0) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Head is masked while empty so uninitialised memory never reaches the output.
    assign out_valid_o  = (level != '0);
    assign out_data_o   = out_valid_o ? mem[rptr] : '0;
    assign fifo_level_o = level;
    assign overflow_o   = overflow;
    assign drop_cnt_o   = drop_cnt;

endmodule

// File: tb/tb_hit_merge_fifo.sv
// Directed and randomized checks of hit_merge_fifo against a queue-based reference model.
module tb_hit_merge_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 15;
    localparam int TS_W   = 8;
    localparam int DW     = 1 + TS_W + ADDR_W;

    logic              sys_clock = 1'b0;
    logic              sys_reset;
    logic              up_valid;
    logic [ADDR_W-1:0] up_addr;
    logic              down_valid;
    logic [ADDR_W-1:0] down_addr;
    logic              ts_clear;
    logic              out_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [4:0]        fifo_level;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              drop_clr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [7:0]    m_ts;
    int            m_cnt;
    logic          m_ov;

    hit_merge_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
        .sys_clock   (sys_clock),
        .sys_reset   (sys_reset),
        .up_valid_i  (up_valid),
        .up_addr_i   (up_addr),
        .down_valid_i(down_valid),
        .down_addr_i (down_addr),
        .ts_clear_i  (ts_clear),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .fifo_level_o(fifo_level),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt),
        .drop_clr_i  (drop_clr)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic set_in(input logic u, input logic [ADDR_W-1:0] ua,
                          input logic d, input logic [ADDR_W-1:0] da, input logic rdy);
        up_valid   = u;
        up_addr    = ua;
        down_valid = d;
        down_addr  = da;
        out_ready  = rdy;
        ts_clear   = 1'b0;
        drop_clr   = 1'b0;
        sys_reset  = 1'b0;
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic step();
        int free;
        int nd;
        if (sys_reset) begin
            mq.delete();
            m_ts  = 8'h00;
            m_cnt = 0;
            m_ov  = 1'b0;
        end else begin
            free = DEPTH - mq.size();
            nd   = 0;
            if (out_ready && mq.size() != 0) begin
                void'(mq.pop_front());
            end
            if (up_valid) begin
                if (free > 0) begin
                    mq.push_back({1'b0, m_ts, up_addr});
                    free--;
                end else begin
                    nd++;
                end
            end
            if (down_valid) begin
                if (free > 0) begin
                    mq.push_back({1'b1, m_ts, down_addr});
                    free--;
                end else begin
                    nd++;
                end
            end
            if (drop_clr) begin
                m_cnt = nd;
                m_ov  = (nd != 0);
            end else begin
                m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
                if (nd != 0) m_ov = 1'b1;
            end
            m_ts = ts_clear ? 8'h00 : m_ts + 8'd1;
        end
        @(posedge sys_clock);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        sys_reset = 1'b1;
        step();
        step();
        sys_reset = 1'b0;
    endtask

    task automatic wait_ts(input logic [7:0] t);
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 300 && m_ts != t; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({out_valid, fifo_level, overflow, drop_cnt, out_data} !== {1'b0, 5'd0, 1'b0, 8'd0, 24'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b lvl=%0d ov=%b cnt=%0d data=%h, want all zero",
                     out_valid, fifo_level, overflow, drop_cnt, out_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        wait_ts(8'h05);
        set_in(1'b1, 15'h1234, 1'b0, '0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        n_cmp++;
        if ({out_valid, fifo_level, out_data} !== {1'b1, 5'd1, 1'b0, 8'h05, 15'h1234}) begin
            n_bad++;
            $display("FAIL single_hit: got v=%b lvl=%0d data=%h, want v=1 lvl=1 data=%h",
                     out_valid, fifo_level, out_data, {1'b0, 8'h05, 15'h1234});
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if ({out_valid, fifo_level} !== {1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL single_pop: got v=%b lvl=%0d, want v=0 lvl=0", out_valid, fifo_level);
        end
    endtask

    task automatic test_dual();
        do_reset();
        wait_ts(8'h10);
        set_in(1'b1, 15'h0001, 1'b1, 15'h7FFF, 1'b0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        n_cmp++;
        if ({fifo_level, out_data} !== {5'd2, 1'b0, 8'h10, 15'h0001}) begin
            n_bad++;
            $display("FAIL dual_first: got lvl=%0d data=%h, want lvl=2 data=%h",
                     fifo_level, out_data, {1'b0, 8'h10, 15'h0001});
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if ({fifo_level, out_data} !== {5'd1, 1'b1, 8'h10, 15'h7FFF}) begin
            n_bad++;
            $display("FAIL dual_second: got lvl=%0d data=%h, want lvl=1 data=%h",
                     fifo_level, out_data, {1'b1, 8'h10, 15'h7FFF});
        end
        step();
        n_cmp++;
        if ({out_valid, fifo_level} !== {1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL dual_drain: got v=%b lvl=%0d, want v=0 lvl=0", out_valid, fifo_level);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 15'(2 * i), 1'b1, 15'(2 * i + 1), 1'b0);
            step();
        end
        n_cmp++;
        if ({fifo_level, overflow, drop_cnt} !== {5'd16, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL fill_16: got lvl=%0d ov=%b cnt=%0d, want lvl=16 ov=0 cnt=0",
                     fifo_level, overflow, drop_cnt);
        end
        step();
        n_cmp++;
        if ({fifo_level, overflow, drop_cnt} !== {5'd16, 1'b1, 8'd2}) begin
            n_bad++;
            $display("FAIL fill_overflow: got lvl=%0d ov=%b cnt=%0d, want lvl=16 ov=1 cnt=2",
                     fifo_level, overflow, drop_cnt);
        end
    endtask

    task automatic test_partial();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 15'h0100, 1'b1, 15'h0200, 1'b0);
            step();
        end
        set_in(1'b1, 15'h0300, 1'b0, '0, 1'b0);
        step();
        set_in(1'b1, 15'h0400, 1'b1, 15'h0500, 1'b0);
        step();
        n_cmp++;
        if ({fifo_level, overflow, drop_cnt} !== {5'd16, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL one_free_dual: got lvl=%0d ov=%b cnt=%0d, want lvl=16 ov=1 cnt=1",
                     fifo_level, overflow, drop_cnt);
        end
        set_in(1'b1, 15'h0600, 1'b0, '0, 1'b1);
        step();
        n_cmp++;
        if ({fifo_level, drop_cnt} !== {5'd15, 8'd2}) begin
            n_bad++;
            $display("FAIL full_push_pop: got lvl=%0d cnt=%0d, want lvl=15 cnt=2", fifo_level, drop_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 200; i++) begin
            set_in(1'b1, 15'(i), 1'b1, 15'(i + 7), 1'b0);
            step();
        end
        n_cmp++;
        if ({fifo_level, drop_cnt} !== {5'd16, 8'd255}) begin
            n_bad++;
            $display("FAIL saturate: got lvl=%0d cnt=%0d, want lvl=16 cnt=255", fifo_level, drop_cnt);
        end
        set_in(1'b1, 15'h0042, 1'b0, '0, 1'b0);
        drop_clr = 1'b1;
        step();
        n_cmp++;
        if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL clear_with_drop: got ov=%b cnt=%0d, want ov=1 cnt=1", overflow, drop_cnt);
        end
    endtask

    task automatic test_timestamp();
        do_reset();
        wait_ts(8'hFF);
        set_in(1'b1, 15'h0AAA, 1'b0, '0, 1'b0);
        step();
        up_addr = 15'h0BBB;
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        n_cmp++;
        if (out_data !== {1'b0, 8'hFF, 15'h0AAA}) begin
            n_bad++;
            $display("FAIL ts_ff: got %h, want %h", out_data, {1'b0, 8'hFF, 15'h0AAA});
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_data !== {1'b0, 8'h00, 15'h0BBB}) begin
            n_bad++;
            $display("FAIL ts_wrap: got %h, want %h", out_data, {1'b0, 8'h00, 15'h0BBB});
        end
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        ts_clear = 1'b1;
        step();
        ts_clear = 1'b0;
        for (int i = 0; i < 3; i++) step();
        set_in(1'b1, 15'h0CCC, 1'b0, '0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 1'b0, 8'h03, 15'h0CCC}) begin
            n_bad++;
            $display("FAIL ts_clear: got v=%b data=%h, want v=1 data=%h",
                     out_valid, out_data, {1'b0, 8'h03, 15'h0CCC});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 15'(i + 1), 1'b0, '0, 1'b0);
            step();
        end
        n_cmp++;
        if (fifo_level !== 5'd5) begin
            n_bad++;
            $display("FAIL pre_reset_level: got %0d, want 5", fifo_level);
        end
        set_in(1'b1, 15'h0777, 1'b1, 15'h0888, 1'b0);
        sys_reset = 1'b1;
        step();
        n_cmp++;
        if ({out_valid, fifo_level, drop_cnt} !== {1'b0, 5'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_mid: got v=%b lvl=%0d cnt=%0d, want v=0 lvl=0 cnt=0",
                     out_valid, fifo_level, drop_cnt);
        end
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        n_cmp++;
        if ({out_valid, fifo_level} !== {1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL reset_hit_discard: got v=%b lvl=%0d, want v=0 lvl=0", out_valid, fifo_level);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] hd;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 9) < 6), 15'($urandom), ($urandom_range(0, 9) < 5),
                   15'($urandom), ($urandom_range(0, 9) < 5));
            ts_clear  = ($urandom_range(0, 63) == 0);
            drop_clr  = ($urandom_range(0, 31) == 0);
            sys_reset = ($urandom_range(0, 499) == 0);
            step();
            hd = (mq.size() != 0) ? mq[0] : '0;
            n_cmp++;
            if ({out_valid, fifo_level, overflow, drop_cnt, out_data} !==
                {(mq.size() != 0), 5'(mq.size()), m_ov, 8'(m_cnt), hd}) begin
                n_bad++;
                $display("FAIL random[%0d]: got v=%b lvl=%0d ov=%b cnt=%0d data=%h, want v=%b lvl=%0d ov=%b cnt=%0d data=%h",
                         i, out_valid, fifo_level, overflow, drop_cnt, out_data,
                         (mq.size() != 0), mq.size(), m_ov, m_cnt, hd);
            end
        end
    endtask

    initial begin
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        sys_reset = 1'b1;
        m_ts  = 8'h00;
        m_cnt = 0;
        m_ov  = 1'b0;
        #1;
        test_reset();
        test_single();
        test_dual();
        test_fill();
        test_partial();
        test_saturate();
        test_timestamp();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
